// File: rtl/piano_note_sequencer.sv
`default_nettype none
// piano_note_sequencer: live note pass-through plus record/replay of (note, duration) segments.
// Rev 1.0
module piano_note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                   iClk,
  input  logic                   iReset_n,
  input  logic [7:0]             iNote,
  input  logic                   iRecord,
  input  logic                   iPlay,
  input  logic                   iStop,
  output logic [7:0]             oNote,
  output logic [1:0]             oState,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oFull
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX    = CW'(DEPTH);
  localparam logic [7:0]    NOTE_RELEASE = 8'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       note_q, note_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic [7:0]       cur_q, cur_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic [7:0]       note_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];

  logic [7:0]       live;
  logic             tick;
  logic [DUR_W-1:0] dur_inc;
  logic [CW-1:0]    count_inc;
  logic [IW-1:0]    idx_next;
  logic             last_entry;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;

  always_comb begin
    live       = (iNote == NOTE_RELEASE) ? 8'd0 : iNote;
    tick       = (presc_q == PRESC_MAX);
    // a tick landing on the same edge as a segment close belongs to the old segment
    dur_inc    = (tick && (dur_q != '1)) ? dur_q + 1'b1 : dur_q;
    count_inc  = count_q + 1'b1;
    idx_next   = idx_q + 1'b1;
    last_entry = ((CW'(idx_q) + 1'b1) == count_q);
    wr_addr    = count_q[IW-1:0];

    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    cur_d   = cur_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (iStop) begin
          state_d = IDLE;
        end else if (iRecord) begin
          count_d = '0;
          full_d  = 1'b0;
          cur_d   = live;
          dur_d   = '0;
          state_d = REC;
        end else if (iPlay && (count_q != '0)) begin
          idx_d   = '0;
          rem_d   = dur_mem[0];
          state_d = PLAY;
        end
      end
      REC: begin
        dur_d = dur_inc;
        if (iStop || (live != cur_q)) begin
          cur_d = live;
          dur_d = '0;
          if (dur_inc != '0) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == COUNT_MAX) begin
              full_d  = 1'b1;
              state_d = IDLE;
            end
          end
          if (iStop) state_d = IDLE;
        end
      end
      PLAY: begin
        if (iStop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (rem_q <= DUR_W'(1)) begin
            if (last_entry) begin
              state_d = IDLE;
            end else begin
              idx_d = idx_next;
              rem_d = dur_mem[idx_next];
            end
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    note_d  = ((state_d == PLAY) && (live == 8'd0)) ? note_mem[idx_d] : live;
    presc_d = ((state_q == IDLE) || (state_d != state_q) || tick) ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      note_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      cur_q   <= '0;
      dur_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      count_q <= count_d;
      full_q  <= full_d;
      cur_q   <= cur_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_en) begin
      note_mem[wr_addr] <= cur_q;
      dur_mem[wr_addr]  <= dur_inc;
    end
  end

  assign oNote  = note_q;
  assign oState = state_q;
  assign oCount = count_q;
  assign oFull  = full_q;
endmodule
`default_nettype wire

// File: tb/tb_piano_note_sequencer.sv
`default_nettype none
// Table-driven bench for piano_note_sequencer (DEPTH=4, TICK_DIV=4).
module tb_piano_note_sequencer;
  logic       clk;
  logic       rst_n;
  logic [7:0] note_in;
  logic       rec, play, stop;
  logic [7:0] note_out;
  logic [1:0] state_out;
  logic [2:0] count_out;
  logic       full_out;

  int errors = 0;
  int checks = 0;

  piano_note_sequencer #(.DEPTH(4), .DUR_W(16), .TICK_DIV(4)) dut (
    .iClk(clk), .iReset_n(rst_n), .iNote(note_in), .iRecord(rec), .iPlay(play),
    .iStop(stop), .oNote(note_out), .oState(state_out), .oCount(count_out), .oFull(full_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] note;
    logic       rec, play, stop;
    int         cycles;
    logic [7:0] e_note;
    logic [1:0] e_state;
    logic [2:0] e_count;
    logic       e_full;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic [7:0] n, input logic r, input logic p,
                              input logic s, input int cyc, input logic [7:0] en,
                              input logic [1:0] es, input logic [2:0] ec, input logic ef);
    vec_t v;
    v.name = nm; v.note = n; v.rec = r; v.play = p; v.stop = s; v.cycles = cyc;
    v.e_note = en; v.e_state = es; v.e_count = ec; v.e_full = ef;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] en, input logic [1:0] es,
                       input logic [2:0] ec, input logic ef);
    checks++;
    if (note_out !== en || state_out !== es || count_out !== ec || full_out !== ef) begin
      errors++;
      $display("FAIL %s @%0t: got note=%0d state=%0d count=%0d full=%0d, expected note=%0d state=%0d count=%0d full=%0d",
               nm, $time, note_out, state_out, count_out, full_out, en, es, ec, ef);
    end
  endtask

  initial begin
    //    name            note rec play stop cyc  note st cnt full
    add("pass24",          24, 0, 0, 0,  1,  24, 0, 0, 0);
    add("release",         99, 0, 0, 0,  1,   0, 0, 0, 0);
    add("pass24b",         24, 0, 0, 0,  1,  24, 0, 0, 0);
    add("rec24",           24, 1, 0, 0, 13,  24, 1, 0, 0);
    add("rec0",             0, 0, 0, 0,  8,   0, 1, 1, 0);
    add("rec36",           36, 0, 0, 0,  4,  36, 1, 2, 0);
    add("rec_stop",        36, 0, 0, 1,  1,  36, 0, 3, 0);
    add("play24",           0, 0, 1, 0, 12,  24, 2, 3, 0);
    add("play0",            0, 0, 0, 0,  8,   0, 2, 3, 0);
    add("play36",           0, 0, 0, 0,  4,  36, 2, 3, 0);
    add("play_end",         0, 0, 0, 0,  1,   0, 0, 3, 0);
    add("ovr_pre",          0, 0, 1, 0,  4,  24, 2, 3, 0);
    add("ovr41",           41, 0, 0, 0,  3,  41, 2, 3, 0);
    add("ovr_resume",       0, 0, 0, 0,  5,  24, 2, 3, 0);
    add("ovr_next",         0, 0, 0, 0,  2,   0, 2, 3, 0);
    add("play_stop",        0, 0, 0, 1,  1,   0, 0, 3, 0);
    add("stop_over_rec",    0, 1, 0, 1,  1,   0, 0, 3, 0);
    add("rec_over_play",    5, 1, 1, 0,  1,   5, 1, 0, 0);
    add("early_change",     6, 0, 0, 0,  1,   6, 1, 0, 0);
    add("early_stop",       6, 0, 0, 1,  1,   6, 0, 0, 0);
    add("play_empty",       0, 0, 1, 0,  1,   0, 0, 0, 0);
    add("rec7",             7, 1, 0, 0,  4,   7, 1, 0, 0);
    add("tick_change",      8, 0, 0, 0,  1,   8, 1, 1, 0);
    add("tick_stop",        8, 0, 0, 1,  1,   8, 0, 1, 0);
    add("ovf10",           10, 1, 0, 0,  5,  10, 1, 0, 0);
    add("ovf11",           11, 0, 0, 0,  4,  11, 1, 1, 0);
    add("ovf12",           12, 0, 0, 0,  4,  12, 1, 2, 0);
    add("ovf13",           13, 0, 0, 0,  4,  13, 1, 3, 0);
    add("ovf_full",        14, 0, 0, 0,  1,  14, 0, 4, 1);
    add("ovf_ignored",     15, 0, 0, 0,  1,  15, 0, 4, 1);
    add("ovf_play10",       0, 0, 1, 0,  4,  10, 2, 4, 1);
    add("ovf_play11",       0, 0, 0, 0,  4,  11, 2, 4, 1);
    add("ovf_play12",       0, 0, 0, 0,  2,  12, 2, 4, 1);

    rst_n = 1'b0; note_in = 8'd24; rec = 1'b0; play = 1'b0; stop = 1'b0;
    #1;
    check("reset_init", 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reset_hold", 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      note_in = vecs[i].note;
      rec     = vecs[i].rec;
      play    = vecs[i].play;
      stop    = vecs[i].stop;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk); #1;
        rec = 1'b0; play = 1'b0; stop = 1'b0;
        check(vecs[i].name, vecs[i].e_note, vecs[i].e_state, vecs[i].e_count, vecs[i].e_full);
      end
    end

    // Asynchronous reset mid-PLAY, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    check("async_reset_hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    note_in = 8'd24;
    @(posedge clk); #1;
    check("post_reset_pass", 24, 0, 0, 0);
    note_in = 8'd0; play = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
    check("post_reset_play_empty", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/piano_note_sequencer.md
# piano_note_sequencer

Record/replay controller between the PS/2 note decoder and the tone generator in the piano design. It passes live note codes through and can record them as (note, duration) segments into an on-chip buffer. On command it replays the buffer to the tone generator, with live key presses overriding playback.

## Interface
- `DEPTH`, 16: number of (note, duration) entries in the buffer.
- `DUR_W`, 16: width of the duration field, in ticks. Durations saturate at 2^DUR_W-1.
- `TICK_DIV`, 50000: clock cycles per duration tick (1 ms at 50 MHz).

- `iClk` in 1: system clock. All logic is on the rising edge.
- `iReset_n` in 1: asynchronous, active-low reset.
- `iNote` in 8: note code from the decoder.
  - 0 = none, 99 = release.
  - Any other value = note index.
- `iRecord` in 1: one-cycle pulse, start recording.
- `iPlay` in 1: one-cycle pulse, start playback.
- `iStop` in 1: one-cycle pulse, stop recording or playback.
- `oNote` out 8: registered note code to the tone generator. 0 = silence.
- `oState` out 2: 0 IDLE, 1 REC, 2 PLAY.
- `oCount` out $clog2(DEPTH)+1: number of valid entries in the buffer.
- `oFull` out 1: high when `oCount` == `DEPTH`.

## Operation
- **Normalization:** live code L = 0 if `iNote` is 0 or 99, otherwise `iNote`. Only L is used internally.
- **Tick prescaler:** counts 0..`TICK_DIV`-1 and emits a one-cycle tick on wrap. It clears to 0 on every state entry.
- **Command priority** (same cycle): `iStop` > `iRecord` > `iPlay`. Commands that do not apply to the current state are ignored.
- **IDLE:**
  - `oNote` <= L.
  - `iRecord` -> clear `oCount` and `oFull`, latch cur=L, dur=0, go to REC.
  - `iPlay` with `oCount`>0 -> idx=0, remaining=dur[0], go to PLAY.
  - `iPlay` with `oCount`=0 is ignored.
- **REC:**
  - `oNote` <= L.
  - dur increments on each tick, saturating.
  - When L != cur:
    - if dur>0, write {cur, dur} at `oCount` and increment `oCount`;
    - if dur=0, drop the segment;
    - in both cases, cur<=L and dur<=0.
  - On the cycle the `DEPTH`th entry is written: `oFull`=1 and go to IDLE.
  - `iStop` -> write the pending segment if dur>0 and the buffer is not full, then go to IDLE.
- **PLAY:**
  - Entry i drives note[i] for exactly dur[i] ticks. On the tick that ends entry i, advance to i+1.
  - After the last entry (idx=`oCount`-1) completes, go to IDLE.
  - `oNote` <= L if L!=0 (live override), else note[idx]. The playback timer keeps running during an override.
  - `iStop` -> go to IDLE immediately.
  - `iRecord` is ignored in PLAY.
- The buffer contents and `oCount` persist across IDLE and PLAY. Only `iRecord` clears them.
- Silence segments (cur=0) are recorded and replayed like notes.

## Timing
- **Reset values:** `oNote`=0, `oState`=0, `oCount`=0, `oFull`=0. Prescaler, dur, idx and cur are all 0.
- A reset asserted mid-REC or mid-PLAY aborts the operation. The buffer contents are then undefined, but `oCount`=0.
- **Live path latency:** `iNote` change -> `oNote` change = 1 clock (IDLE, REC, PLAY override).
- **State change:** `oState` updates 1 clock after the command pulse.
- **Playback start:** `oNote`=note[0] from the cycle `oState` becomes 2.
- **Segment boundaries:**
  - REC: a segment write and the `oCount` increment occur 1 clock after L changes.
  - PLAY: playback advances on the tick edge.
- **Duration accounting:** a segment recorded as D ticks replays for D×`TICK_DIV` cycles (±`TICK_DIV` of quantization at recording).
- **Simultaneous events:**
  - A note change on the same cycle as `iStop` in REC: write the old segment, discard the new one.
  - A tick on the same cycle as a note change: count the tick into the old segment first.

## Test plan
- **Reset and pass-through:** bench uses `TICK_DIV`=4, `DEPTH`=4. Apply reset, then `iNote`=24 -> `oNote`=24 after 1 clk; `iNote`=99 -> `oNote`=0. Outputs are 0 during reset.
- **Record and replay:**
  - Record 24 for 3 ticks, 0 for 2 ticks, 36 for 1 tick, then `iStop` -> `oCount`=3, `oState`=0.
  - `iPlay` -> `oNote`=24 for 12 cycles, 0 for 8, 36 for 4, then `oState`=0.
- **Overflow:** in REC, generate 5 note changes with ≥1 tick each -> after the 4th write, `oFull`=1, `oState`=0 and `oCount`=4. The 5th segment is not stored.
- **Override and stop:**
  - During PLAY of entry 24, `iNote`=41 -> `oNote`=41. Release -> `oNote` resumes 24 with the timer unaffected.
  - `iStop` -> `oState`=0 next clock.
- **Priority and edge cases:**
  - `iRecord` and `iPlay` in the same cycle from IDLE -> REC.
  - `iPlay` with `oCount`=0 -> stays IDLE.
  - A note change within the first tick of REC -> no entry is written.
- **Async reset mid-PLAY:** deassert `iReset_n` between clock edges -> `oNote`=0, `oState`=0 and `oCount`=0 immediately, without waiting for a clock edge.
